// File: rtl/switch_merge.sv
// switch_merge: two-port to one-stream merger. Each input port owns a small
// FIFO; a round-robin arbiter drains them into one registered valid/ready
// output stage. Index 0 of every per-port array is port A, index 1 is port B.
module switch_merge #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       vld_a,
    input  logic [ADDR_W-1:0]          addr_a,
    input  logic [DATA_W-1:0]          data_a,
    output logic                       rdy_a,
    input  logic                       vld_b,
    input  logic [ADDR_W-1:0]          addr_b,
    input  logic [DATA_W-1:0]          data_b,
    output logic                       rdy_b,
    output logic                       vld,
    output logic [ADDR_W-1:0]          addr,
    output logic [DATA_W-1:0]          data,
    output logic                       src,
    input  logic                       rdy,
    output logic [$clog2(DEPTH):0]     cnt_a,
    output logic [$clog2(DEPTH):0]     cnt_b
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pkt_t;

    pkt_t             mem [2][DEPTH];
    logic [PTR_W-1:0] wr_ptr [2];
    logic [PTR_W-1:0] rd_ptr [2];
    logic [CNT_W-1:0] cnt_q  [2];
    pkt_t             in_pkt [2];

    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] not_empty;
    logic       load_en;
    logic       grant;
    logic       last_grant;
    pkt_t       sel_pkt;

    // Ready depends only on occupancy; a same-cycle pop never frees a full FIFO
    assign rdy_a = (cnt_q[0] != CNT_W'(DEPTH));
    assign rdy_b = (cnt_q[1] != CNT_W'(DEPTH));
    assign cnt_a = cnt_q[0];
    assign cnt_b = cnt_q[1];

    // Push/pop decode and round-robin grant (ties go to the port not granted last)
    always_comb begin
        in_pkt[0]    = {addr_a, data_a};
        in_pkt[1]    = {addr_b, data_b};
        push[0]      = vld_a && rdy_a;
        push[1]      = vld_b && rdy_b;
        not_empty[0] = (cnt_q[0] != '0);
        not_empty[1] = (cnt_q[1] != '0);
        load_en      = !vld || rdy;
        grant        = (not_empty == 2'b11) ? ~last_grant : not_empty[1];
        pop[0]       = load_en && not_empty[0] && !grant;
        pop[1]       = load_en && not_empty[1] && grant;
        sel_pkt      = grant ? mem[1][rd_ptr[1]] : mem[0][rd_ptr[0]];
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                mem[p][wr_ptr[p]] <= in_pkt[p];
            end
        end
    end

    // FIFO pointers (wrap mod DEPTH) and occupancy counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                cnt_q[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) begin
                    wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
                end
                if (pop[p]) begin
                    rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
                end
                if (push[p] && !pop[p]) begin
                    cnt_q[p] <= cnt_q[p] + CNT_W'(1);
                end else if (!push[p] && pop[p]) begin
                    cnt_q[p] <= cnt_q[p] - CNT_W'(1);
                end
            end
        end
    end

    // Output stage: load a granted head when free, hold everything while stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld        <= 1'b0;
            addr       <= '0;
            data       <= '0;
            src        <= 1'b0;
            last_grant <= 1'b1;
        end else if (load_en) begin
            if (not_empty != 2'b00) begin
                vld        <= 1'b1;
                addr       <= sel_pkt.addr;
                data       <= sel_pkt.data;
                src        <= grant;
                last_grant <= grant;
            end else begin
                vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_switch_merge.sv
// tb_switch_merge: directed vector tables plus a per-port scoreboard that
// records accepted pushes and checks every transfer leaving the merger.
module tb_switch_merge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        vld_a, vld_b, rdy;
    logic [7:0]  addr_a, addr_b;
    logic [15:0] data_a, data_b;
    logic        rdy_a, rdy_b, vld, src;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [2:0]  cnt_a, cnt_b;

    int n_chk  = 0;
    int n_fail = 0;
    int rcv_b  = 0;

    logic [23:0] exp_a [$];
    logic [23:0] exp_b [$];

    typedef struct {
        logic        va;
        logic [7:0]  aa;
        logic [15:0] da;
        logic        vb;
        logic [7:0]  ab;
        logic [15:0] db;
        logic        r;
        logic        evld;
        logic [7:0]  eaddr;
        logic [15:0] edata;
        logic        esrc;
        logic [2:0]  eca;
        logic [2:0]  ecb;
        logic        erdya;
        logic        erdyb;
    } vec_t;

    vec_t vq [$];

    switch_merge dut (
        .clk    (clk),
        .rstn   (rstn),
        .vld_a  (vld_a),
        .addr_a (addr_a),
        .data_a (data_a),
        .rdy_a  (rdy_a),
        .vld_b  (vld_b),
        .addr_b (addr_b),
        .data_b (data_b),
        .rdy_b  (rdy_b),
        .vld    (vld),
        .addr   (addr),
        .data   (data),
        .src    (src),
        .rdy    (rdy),
        .cnt_a  (cnt_a),
        .cnt_b  (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic va, input logic [7:0] aa, input logic [15:0] da,
                                input logic vb, input logic [7:0] ab, input logic [15:0] db,
                                input logic r, input logic evld, input logic [7:0] eaddr,
                                input logic [15:0] edata, input logic esrc,
                                input logic [2:0] eca, input logic [2:0] ecb,
                                input logic erdya, input logic erdyb);
        vec_t v;
        v.va = va; v.aa = aa; v.da = da;
        v.vb = vb; v.ab = ab; v.db = db;
        v.r = r; v.evld = evld; v.eaddr = eaddr; v.edata = edata; v.esrc = esrc;
        v.eca = eca; v.ecb = ecb; v.erdya = erdya; v.erdyb = erdyb;
        return v;
    endfunction

    // Scoreboard: check the transfer about to happen, then record accepted pushes
    task automatic sb_sample();
        logic [23:0] e;
        if (rstn) begin
            if (vld && rdy) begin
                if (src == 1'b0) begin
                    chk("sb_a_expected_pkt", 32'(exp_a.size() != 0), 32'd1);
                    if (exp_a.size() != 0) begin
                        e = exp_a.pop_front();
                        chk("sb_a_pkt", 32'({addr, data}), 32'(e));
                    end
                end else begin
                    chk("sb_b_expected_pkt", 32'(exp_b.size() != 0), 32'd1);
                    if (exp_b.size() != 0) begin
                        e = exp_b.pop_front();
                        chk("sb_b_pkt", 32'({addr, data}), 32'(e));
                        rcv_b++;
                    end
                end
            end
            if (vld_a && rdy_a) exp_a.push_back({addr_a, data_a});
            if (vld_b && rdy_b) exp_b.push_back({addr_b, data_b});
        end
    endtask

    task automatic tick();
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        vld_a = 1'b0; addr_a = '0; data_a = '0;
        vld_b = 1'b0; addr_b = '0; data_b = '0;
        rdy   = r;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle(1'b1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_a.delete();
        exp_b.delete();
    endtask

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            vld_a = vq[i].va; addr_a = vq[i].aa; data_a = vq[i].da;
            vld_b = vq[i].vb; addr_b = vq[i].ab; data_b = vq[i].db;
            rdy   = vq[i].r;
            tick();
            chk($sformatf("vec%0d_vld", i),   32'(vld),   32'(vq[i].evld));
            chk($sformatf("vec%0d_addr", i),  32'(addr),  32'(vq[i].eaddr));
            chk($sformatf("vec%0d_data", i),  32'(data),  32'(vq[i].edata));
            chk($sformatf("vec%0d_src", i),   32'(src),   32'(vq[i].esrc));
            chk($sformatf("vec%0d_cnt_a", i), 32'(cnt_a), 32'(vq[i].eca));
            chk($sformatf("vec%0d_cnt_b", i), 32'(cnt_b), 32'(vq[i].ecb));
            chk($sformatf("vec%0d_rdy_a", i), 32'(rdy_a), 32'(vq[i].erdya));
            chk($sformatf("vec%0d_rdy_b", i), 32'(rdy_b), 32'(vq[i].erdyb));
        end
    endtask

    initial begin
        int t3;
        int t4;
        int pushed;
        int base_b;
        int cyc;
        logic acc;

        // Single packet on A: visible two edges after it is driven, for one cycle
        vq.push_back(mk(1, 8'h01, 16'hAAAA, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 16'h0000, 0, 3'd1, 3'd0, 1, 1));
        vq.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 1, 8'h01, 16'hAAAA, 0, 3'd0, 3'd0, 1, 1));
        vq.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 0, 8'h01, 16'hAAAA, 0, 3'd0, 3'd0, 1, 1));
        // Round-robin from reset: 10,20,11,21
        t3 = vq.size();
        vq.push_back(mk(1, 8'h10, 16'h1010, 1, 8'h20, 16'h2020, 1, 0, 8'h00, 16'h0000, 0, 3'd1, 3'd1, 1, 1));
        vq.push_back(mk(1, 8'h11, 16'h1111, 1, 8'h21, 16'h2121, 1, 1, 8'h10, 16'h1010, 0, 3'd1, 3'd2, 1, 1));
        vq.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 1, 8'h20, 16'h2020, 1, 3'd1, 3'd1, 1, 1));
        vq.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 1, 8'h11, 16'h1111, 0, 3'd0, 3'd1, 1, 1));
        vq.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 1, 8'h21, 16'h2121, 1, 3'd0, 3'd0, 1, 1));
        vq.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 0, 8'h21, 16'h2121, 1, 3'd0, 3'd0, 1, 1));
        // Backpressure: fill A while stalled, pushes at full are refused, then drain
        t4 = vq.size();
        vq.push_back(mk(1, 8'h30, 16'h3000, 0, 8'h00, 16'h0000, 0, 0, 8'h21, 16'h2121, 1, 3'd1, 3'd0, 1, 1));
        vq.push_back(mk(1, 8'h31, 16'h3001, 0, 8'h00, 16'h0000, 0, 1, 8'h30, 16'h3000, 0, 3'd1, 3'd0, 1, 1));
        vq.push_back(mk(1, 8'h32, 16'h3002, 0, 8'h00, 16'h0000, 0, 1, 8'h30, 16'h3000, 0, 3'd2, 3'd0, 1, 1));
        vq.push_back(mk(1, 8'h33, 16'h3003, 0, 8'h00, 16'h0000, 0, 1, 8'h30, 16'h3000, 0, 3'd3, 3'd0, 1, 1));
        vq.push_back(mk(1, 8'h34, 16'h3004, 0, 8'h00, 16'h0000, 0, 1, 8'h30, 16'h3000, 0, 3'd4, 3'd0, 0, 1));
        vq.push_back(mk(1, 8'h35, 16'h3005, 0, 8'h00, 16'h0000, 0, 1, 8'h30, 16'h3000, 0, 3'd4, 3'd0, 0, 1));
        vq.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 1, 8'h30, 16'h3000, 0, 3'd4, 3'd0, 0, 1));
        vq.push_back(mk(1, 8'h36, 16'h3006, 0, 8'h00, 16'h0000, 1, 1, 8'h31, 16'h3001, 0, 3'd3, 3'd0, 1, 1));
        vq.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 1, 8'h32, 16'h3002, 0, 3'd2, 3'd0, 1, 1));
        vq.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 1, 8'h33, 16'h3003, 0, 3'd1, 3'd0, 1, 1));
        vq.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 1, 8'h34, 16'h3004, 0, 3'd0, 3'd0, 1, 1));
        vq.push_back(mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 0, 8'h34, 16'h3004, 0, 3'd0, 3'd0, 1, 1));

        // Reset held for 4 cycles
        rstn = 1'b0;
        idle(1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("reset_vld", 32'(vld), 32'd0);
        chk("reset_addr", 32'(addr), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        chk("reset_rdy_a", 32'(rdy_a), 32'd1);
        chk("reset_rdy_b", 32'(rdy_b), 32'd1);
        chk("reset_cnt_a", 32'(cnt_a), 32'd0);
        chk("reset_cnt_b", 32'(cnt_b), 32'd0);
        rstn = 1'b1;

        run_vecs(0, t3 - 1);
        do_reset();
        run_vecs(t3, t4 - 1);
        run_vecs(t4, vq.size() - 1);
        chk("bp_queue_a_drained", 32'(exp_a.size()), 32'd0);

        // Wrap: 20 packets on B with downstream ready toggling every cycle
        base_b = rcv_b;
        pushed = 0;
        cyc    = 0;
        while ((rcv_b - base_b) < 20 && cyc < 300) begin
            idle(cyc[0] == 1'b0);
            vld_b  = (pushed < 20);
            addr_b = 8'(8'h50 + pushed);
            data_b = 16'(16'h5000 + pushed);
            acc    = vld_b && rdy_b;
            tick();
            if (acc) pushed++;
            chk("wrap_cnt_b_bound", 32'(cnt_b <= 3'd4), 32'd1);
            cyc++;
        end
        chk("wrap_all_received", 32'(rcv_b - base_b), 32'd20);
        chk("wrap_queue_b_empty", 32'(exp_b.size()), 32'd0);

        // Reset mid-stream with packets queued on both ports
        idle(1'b0);
        for (int i = 0; i < 3; i++) begin
            vld_a = 1'b1; addr_a = 8'(8'h60 + i); data_a = 16'(16'h6000 + i);
            vld_b = 1'b1; addr_b = 8'(8'h70 + i); data_b = 16'(16'h7000 + i);
            tick();
        end
        idle(1'b0);
        chk("pre_reset_vld", 32'(vld), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("midreset_vld", 32'(vld), 32'd0);
        chk("midreset_cnt_a", 32'(cnt_a), 32'd0);
        chk("midreset_cnt_b", 32'(cnt_b), 32'd0);
        chk("midreset_rdy_a", 32'(rdy_a), 32'd1);
        chk("midreset_rdy_b", 32'(rdy_b), 32'd1);
        exp_a.delete();
        exp_b.delete();
        idle(1'b1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_stale_vld", 32'(vld), 32'd0);
        end
        vld_a = 1'b1; addr_a = 8'h7E; data_a = 16'h7E7E;
        tick();
        idle(1'b1);
        tick();
        chk("post_reset_vld", 32'(vld), 32'd1);
        chk("post_reset_addr", 32'(addr), 32'h7E);
        chk("post_reset_src", 32'(src), 32'd0);
        tick();
        chk("post_reset_queues_empty", 32'(exp_a.size() + exp_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
